// File: rtl/acc_core_p.sv
`default_nettype none
// ============================================================================
//  Module   : acc_core_p
//  Purpose  : Parametrised accumulator core with programmable RF/IM,
//             sequential restoring divider, link-register call/return.
//  Revision : 1.0 - initial release
// ============================================================================
module acc_core_p #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic            main_clk,
    input  logic            rst,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [3+AW:0]   prog_data,
    input  logic            rf_we,
    input  logic [AW-1:0]   rf_addr,
    input  logic [DW-1:0]   rf_data,
    input  logic            start,
    output logic            busy,
    output logic            halted,
    output logic [DW-1:0]   out,
    output logic [DW-1:0]   ext,
    output logic            cb
);

    localparam int NW = 1 << AW;
    localparam int CW = $clog2(DW + 1);

    localparam logic [3:0] c_op_misc = 4'h0;
    localparam logic [3:0] c_op_add  = 4'h1;
    localparam logic [3:0] c_op_rsub = 4'h2;
    localparam logic [3:0] c_op_mul  = 4'h3;
    localparam logic [3:0] c_op_div  = 4'h4;
    localparam logic [3:0] c_op_and  = 4'h5;
    localparam logic [3:0] c_op_xor  = 4'h6;
    localparam logic [3:0] c_op_cmp  = 4'h7;
    localparam logic [3:0] c_op_call = 4'h8;
    localparam logic [3:0] c_op_ld   = 4'h9;
    localparam logic [3:0] c_op_st   = 4'hA;
    localparam logic [3:0] c_op_ret  = 4'hB;
    localparam logic [3:0] c_op_jz   = 4'hC;
    localparam logic [3:0] c_op_jc   = 4'hD;
    localparam logic [3:0] c_op_or   = 4'hE;
    localparam logic [3:0] c_op_hlt  = 4'hF;

    localparam logic [AW-1:0] c_sub_shl = AW'(1);
    localparam logic [AW-1:0] c_sub_shr = AW'(2);
    localparam logic [AW-1:0] c_sub_ror = AW'(3);
    localparam logic [AW-1:0] c_sub_rol = AW'(4);
    localparam logic [AW-1:0] c_sub_asr = AW'(5);
    localparam logic [AW-1:0] c_sub_inc = AW'(6);
    localparam logic [AW-1:0] c_sub_dec = AW'(7);

    localparam logic [CW-1:0] c_div_last = CW'(DW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DIV  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d, lr_q, lr_d;
    logic [DW-1:0]   acc_q, acc_d, ext_q, ext_d, out_q, out_d;
    logic            cb_q, cb_d;
    logic [DW-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Storage has no reset: program and data survive rst.
    logic [DW-1:0]   rf_q [NW];
    logic [3+AW:0]   im_q [NW];

    logic            im_wr_en, rf_wr_en;
    logic [AW-1:0]   rf_wr_addr;
    logic [DW-1:0]   rf_wr_data;

    logic [3+AW:0]   instr;
    logic [3:0]      opcode;
    logic [AW-1:0]   operand;
    logic [DW-1:0]   r_val;
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   rem_low;
    logic            rem_ge;

    assign instr   = im_q[pc_q];
    assign opcode  = instr[3+AW -: 4];
    assign operand = instr[AW-1:0];
    assign r_val   = rf_q[operand];
    assign prod    = {{DW{1'b0}}, acc_q} * {{DW{1'b0}}, r_val};

    // Shifted partial remainder is {rem_q[DW-1], rem_low}; a set top bit always exceeds the divisor.
    assign rem_low = {rem_q[DW-2:0], quo_q[DW-1]};
    assign rem_ge  = rem_q[DW-1] | (rem_low >= dvs_q);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        lr_d       = lr_q;
        acc_d      = acc_q;
        ext_d      = ext_q;
        cb_d       = cb_q;
        out_d      = out_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        im_wr_en   = 1'b0;
        rf_wr_en   = 1'b0;
        rf_wr_addr = rf_addr;
        rf_wr_data = rf_data;

        case (state_q)
            S_IDLE, S_HALT: begin
                im_wr_en = prog_we;
                rf_wr_en = rf_we;
                if (start) begin
                    state_d = S_EXEC;
                    pc_d    = '0;
                    acc_d   = '0;
                    ext_d   = '0;
                    cb_d    = 1'b0;
                    lr_d    = '0;
                end
            end
            S_EXEC: begin
                pc_d = pc_q + AW'(1);
                case (opcode)
                    c_op_misc: begin
                        case (operand)
                            c_sub_shl: acc_d = {acc_q[DW-2:0], 1'b0};
                            c_sub_shr: acc_d = {1'b0, acc_q[DW-1:1]};
                            c_sub_ror: acc_d = {acc_q[0], acc_q[DW-1:1]};
                            c_sub_rol: acc_d = {acc_q[DW-2:0], acc_q[DW-1]};
                            c_sub_asr: acc_d = {acc_q[DW-1], acc_q[DW-1:1]};
                            c_sub_inc: {cb_d, acc_d} = {1'b0, acc_q} + {{DW{1'b0}}, 1'b1};
                            c_sub_dec: begin
                                acc_d = acc_q - {{(DW-1){1'b0}}, 1'b1};
                                cb_d  = (acc_q == '0);
                            end
                            default: ;
                        endcase
                    end
                    c_op_add:  {cb_d, acc_d} = {1'b0, acc_q} + {1'b0, r_val};
                    c_op_rsub: begin
                        acc_d = r_val - acc_q;
                        cb_d  = (r_val < acc_q);
                    end
                    c_op_mul:  {ext_d, acc_d} = prod;
                    c_op_div: begin
                        state_d = S_DIV;
                        pc_d    = pc_q;
                        rem_d   = '0;
                        quo_d   = r_val;
                        dvs_d   = acc_q;
                        cnt_d   = '0;
                    end
                    c_op_and:  acc_d = acc_q & r_val;
                    c_op_xor:  acc_d = acc_q ^ r_val;
                    c_op_or:   acc_d = acc_q | r_val;
                    c_op_cmp:  cb_d  = (acc_q < r_val);
                    c_op_call: begin
                        lr_d = pc_q + AW'(1);
                        pc_d = operand;
                    end
                    c_op_ret:  pc_d  = lr_q;
                    c_op_ld:   acc_d = r_val;
                    c_op_st: begin
                        rf_wr_en   = 1'b1;
                        rf_wr_addr = operand;
                        rf_wr_data = acc_q;
                    end
                    c_op_jz:   if (acc_q == '0) pc_d = operand;
                    c_op_jc:   if (cb_q) pc_d = operand;
                    c_op_hlt:  if (operand == '1) state_d = S_HALT;
                    default: ;
                endcase
                if (opcode != c_op_div) out_d = acc_d;
            end
            S_DIV: begin
                if (cnt_q != c_div_last) begin
                    rem_d = rem_ge ? (rem_low - dvs_q) : rem_low;
                    quo_d = {quo_q[DW-2:0], rem_ge};
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    // A zero divisor naturally yields quotient all ones and remainder = dividend.
                    acc_d   = quo_q;
                    ext_d   = rem_q;
                    cb_d    = (dvs_q == '0);
                    out_d   = quo_q;
                    pc_d    = pc_q + AW'(1);
                    state_d = S_EXEC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            lr_q    <= '0;
            acc_q   <= '0;
            ext_q   <= '0;
            cb_q    <= 1'b0;
            out_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lr_q    <= lr_d;
            acc_q   <= acc_d;
            ext_q   <= ext_d;
            cb_q    <= cb_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge main_clk) begin
        if (im_wr_en) im_q[prog_addr] <= prog_data;
        if (rf_wr_en) rf_q[rf_wr_addr] <= rf_wr_data;
    end

    assign busy   = (state_q == S_EXEC) || (state_q == S_DIV);
    assign halted = (state_q == S_HALT);
    assign out    = out_q;
    assign ext    = ext_q;
    assign cb     = cb_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_core_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_core_p
//  Purpose  : Self-checking bench for acc_core_p against an ISA-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acc_core_p;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int NW    = 16;
    localparam int MASK  = 255;
    localparam int AMASK = 15;

    logic          main_clk = 1'b0;
    logic          rst, prog_we, rf_we, start;
    logic [AW-1:0] prog_addr, rf_addr;
    logic [3+AW:0] prog_data;
    logic [DW-1:0] rf_data;
    logic          busy, halted, cb;
    logic [DW-1:0] out, ext;

    acc_core_p #(.DW(DW), .AW(AW)) dut (
        .main_clk (main_clk),
        .rst      (rst),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .start    (start),
        .busy     (busy),
        .halted   (halted),
        .out      (out),
        .ext      (ext),
        .cb       (cb)
    );

    always #5 main_clk = ~main_clk;

    int vectors     = 0;
    int miscompares = 0;

    int m_im [NW];
    int m_rf [NW];
    int m_out = 0;
    int m_ext, m_cb;
    int exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic int ins(input int op, input int a);
        return ((op & 15) << AW) | (a & AMASK);
    endfunction

    task automatic wr_im(input int a, input int d);
        prog_we = 1'b1; prog_addr = AW'(a); prog_data = (4+AW)'(d);
        @(posedge main_clk); #1;
        prog_we = 1'b0;
        m_im[a] = d;
    endtask

    task automatic wr_rf(input int a, input int d);
        rf_we = 1'b1; rf_addr = AW'(a); rf_data = DW'(d);
        @(posedge main_clk); #1;
        rf_we = 1'b0;
        m_rf[a] = d;
    endtask

    // Instruction-level interpreter: expected `out` after every clock edge until HLT retires.
    task automatic model_run();
        int pc, acc, ext_v, cb_v, lr, r, op, a, npc, extra, steps;
        bit done;
        pc = 0; acc = 0; ext_v = 0; cb_v = 0; lr = 0; steps = 0; done = 0;
        exp_q.delete();
        while (!done) begin
            if (steps > 500) begin
                $display("FAIL model_run: program never halts");
                $fatal(1);
            end
            op = (m_im[pc] >> AW) & 15;
            a  = m_im[pc] & AMASK;
            r  = m_rf[a];
            npc = (pc + 1) % NW;
            extra = 0;
            case (op)
                0: case (a)
                    1: acc = (acc * 2) & MASK;
                    2: acc = acc / 2;
                    3: acc = (acc / 2) | ((acc & 1) << (DW-1));
                    4: acc = ((acc * 2) & MASK) | (acc >> (DW-1));
                    5: acc = (acc / 2) | (acc & (1 << (DW-1)));
                    6: begin cb_v = (acc == MASK); acc = (acc + 1) & MASK; end
                    7: begin cb_v = (acc == 0); acc = (acc - 1) & MASK; end
                    default: ;
                endcase
                1: begin cb_v = ((acc + r) > MASK); acc = (acc + r) & MASK; end
                2: begin cb_v = (r < acc); acc = (r - acc) & MASK; end
                3: begin ext_v = (acc * r) >> DW; acc = (acc * r) & MASK; end
                4: begin
                    extra = DW + 1;
                    if (acc == 0) begin acc = MASK; ext_v = r; cb_v = 1; end
                    else begin ext_v = r % acc; acc = r / acc; cb_v = 0; end
                end
                5:  acc = acc & r;
                6:  acc = acc ^ r;
                14: acc = acc | r;
                7:  cb_v = (acc < r);
                8:  begin lr = npc; npc = a; end
                9:  acc = r;
                10: m_rf[a] = acc;
                11: npc = lr;
                12: if (acc == 0) npc = a;
                13: if (cb_v != 0) npc = a;
                15: if (a == AMASK) done = 1;
                default: ;
            endcase
            repeat (extra) exp_q.push_back(m_out);
            m_out = acc;
            exp_q.push_back(m_out);
            pc = npc;
            steps++;
        end
        m_ext = ext_v;
        m_cb  = cb_v;
    endtask

    // poke: attempt IM/RF writes and a second start while busy; co_wr: RF write alongside start.
    task automatic run_prog(input bit poke, input bit co_wr, input int co_addr, input int co_val);
        int n;
        if (co_wr) m_rf[co_addr] = co_val;
        model_run();
        n = exp_q.size();
        start = 1'b1;
        if (co_wr) begin rf_we = 1'b1; rf_addr = AW'(co_addr); rf_data = DW'(co_val); end
        @(posedge main_clk); #1;
        start = 1'b0; rf_we = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("halted_after_start", halted, 0);
        for (int c = 0; c < n; c++) begin
            if (poke && c == 1) begin
                prog_we = 1'b1; prog_addr = '0; prog_data = 8'hFF;
                rf_we = 1'b1; rf_addr = 4'd3; rf_data = DW'($urandom_range(16, MASK));
                start = 1'b1;
            end
            @(posedge main_clk); #1;
            prog_we = 1'b0; rf_we = 1'b0; start = 1'b0;
            chk("out_trace", out, exp_q[c]);
            if (c < n - 1) chk("busy_running", busy, 1);
        end
        chk("halted_end", halted, 1);
        chk("busy_end", busy, 0);
        chk("ext_end", ext, m_ext);
        chk("cb_end", cb, m_cb);
    endtask

    task automatic rand_prog();
        int len, op, a;
        int ops [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12, 13, 14, 15};
        for (int i = 0; i < NW; i++) wr_rf(i, $urandom_range(0, MASK));
        len = $urandom_range(2, NW);
        for (int i = 0; i < len - 1; i++) begin
            op = ops[$urandom_range(0, 14)];
            if (op == 8 || op == 12 || op == 13) a = $urandom_range(i + 1, len - 1);
            else if (op == 15)                   a = $urandom_range(0, AMASK - 1);
            else                                 a = $urandom_range(0, AMASK);
            wr_im(i, ins(op, a));
        end
        wr_im(len - 1, ins(15, AMASK));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; prog_we = 1'b0; rf_we = 1'b0; start = 1'b0;
        prog_addr = '0; prog_data = '0; rf_addr = '0; rf_data = '0;
        repeat (2) @(posedge main_clk); #1;
        chk("rst_out", out, 0);
        chk("rst_ext", ext, 0);
        chk("rst_cb", cb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        rst = 1'b0;
        for (int i = 0; i < NW; i++) begin wr_im(i, 0); wr_rf(i, 0); end

        // ADD with carry
        wr_rf(0, 224); wr_rf(1, 240);
        wr_im(0, ins(9, 0)); wr_im(1, ins(1, 1)); wr_im(2, ins(15, 15));
        run_prog(0, 0, 0, 0);
        chk("add_out", out, 208);
        chk("add_cb", cb, 1);

        // MUL high half
        wr_rf(0, 240); wr_rf(1, 224);
        wr_im(1, ins(3, 1));
        run_prog(0, 0, 0, 0);
        chk("mul_out", out, 8'h00);
        chk("mul_ext", ext, 8'hD2);

        // DIV and divide-by-zero
        wr_rf(3, 15); wr_rf(4, 200);
        wr_im(0, ins(9, 3)); wr_im(1, ins(4, 4)); wr_im(2, ins(15, 15));
        run_prog(0, 0, 0, 0);
        chk("div_out", out, 13);
        chk("div_ext", ext, 5);
        chk("div_cb", cb, 0);
        wr_rf(3, 0);
        run_prog(0, 0, 0, 0);
        chk("div0_out", out, 255);
        chk("div0_ext", ext, 200);
        chk("div0_cb", cb, 1);

        // Countdown loop through DEC/JZ/CALL
        wr_rf(0, 3);
        wr_im(0, ins(9, 0)); wr_im(1, ins(0, 7)); wr_im(2, ins(12, 4));
        wr_im(3, ins(8, 1)); wr_im(4, ins(15, 15));
        run_prog(0, 0, 0, 0);
        chk("loop_out", out, 0);

        // CALL/RET
        wr_rf(0, 5); wr_rf(1, 7);
        wr_im(0, ins(8, 3)); wr_im(1, ins(1, 1)); wr_im(2, ins(15, 15));
        wr_im(3, ins(9, 0)); wr_im(4, ins(11, 0));
        run_prog(0, 0, 0, 0);
        chk("ret_out", out, 12);

        // Program port lockout while busy, then identical rerun
        wr_rf(3, 15); wr_rf(4, 200);
        wr_im(0, ins(9, 3)); wr_im(1, ins(4, 4)); wr_im(2, ins(15, 15));
        run_prog(1, 0, 0, 0);
        chk("lock_out1", out, 13);
        run_prog(0, 0, 0, 0);
        chk("lock_out2", out, 13);
        chk("lock_ext2", ext, 5);

        // RF write alongside start is visible to the first instruction
        wr_im(0, ins(9, 6)); wr_im(1, ins(15, 15));
        run_prog(0, 1, 6, 77);
        chk("cowr_out", out, 77);

        for (int t = 0; t < 25; t++) begin
            rand_prog();
            run_prog(0, 0, 0, 0);
        end

        // No HLT: PC wraps and the core keeps running
        for (int i = 0; i < NW; i++) wr_im(i, 0);
        start = 1'b1; @(posedge main_clk); #1; start = 1'b0;
        repeat (40) @(posedge main_clk);
        #1;
        chk("wrap_busy", busy, 1);
        chk("wrap_halted", halted, 0);
        rst = 1'b1; @(posedge main_clk); #1; rst = 1'b0;
        m_out = 0;

        // Asynchronous reset in the middle of a DIV
        wr_rf(0, 240); wr_rf(1, 224); wr_rf(4, 200);
        wr_im(0, ins(9, 0)); wr_im(1, ins(3, 1)); wr_im(2, ins(9, 0));
        wr_im(3, ins(1, 1)); wr_im(4, ins(4, 4)); wr_im(5, ins(15, 15));
        start = 1'b1; @(posedge main_clk); #1; start = 1'b0;
        repeat (7) @(posedge main_clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_out", out, 208);
        chk("pre_rst_ext", ext, 8'hD2);
        chk("pre_rst_cb", cb, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out", out, 0);
        chk("arst_ext", ext, 0);
        chk("arst_cb", cb, 0);
        chk("arst_busy", busy, 0);
        chk("arst_halted", halted, 0);
        @(posedge main_clk); #1; rst = 1'b0;
        m_out = 0;
        run_prog(0, 0, 0, 0);
        chk("post_rst_ext", ext, 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
